edge_monitor: RTL and testbench
===============================

# edge_monitor

Parametrised multi-channel edge monitor. It is the synthesizable, in-design counterpart of the team's `$rose` assertion checks. It samples NCH single-bit signals on `clk` and produces registered rise, fall and mode-qualified edge pulses. It keeps a saturating edge count per channel and runs an armed "edge-within-window" checker that reports pass or fail. It sits beside the design under observation, in a debug/monitor wrapper or a bench, and is driven by a status register block.

## Interface
Parameters:
- NCH, 4, number of monitored channels (≥1)
- CNT_W, 8, width of each per-channel edge counter
- WIN_W, 4, width of the checker window length

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- sig_i  in  NCH  monitored signals, already synchronous to clk
- mode_i  in  2*NCH  per-channel mode, channel n at [2n+1:2n]: 00 rise, 01 fall, 10 both, 11 off
- clr_i  in  1  zero all edge counters
- arm_i  in  1  start checker (accepted only in IDLE)
- sel_i  in  $clog2(NCH) (min 1)  checker channel, latched on arm
- window_i  in  WIN_W  checker window in cycles, latched on arm
- rose_o  out  NCH  rising edge seen
- fell_o  out  NCH  falling edge seen
- edge_o  out  NCH  mode-qualified edge
- count_o  out  NCH*CNT_W  per-channel edge count, channel n at [n*CNT_W +: CNT_W]
- busy_o  out  1  checker in WAIT
- pass_o  out  1  one-cycle pass pulse
- fail_o  out  1  one-cycle fail pulse

## Operation
- Per channel, the previous-sample register `sig_q` resets to 0. A channel already high on the first post-reset edge therefore reports a rise. This matches `$rose` with the bit default of 0.
- At each posedge, with no reset:
  - `rose_o[n] <= sig_i[n] & ~sig_q[n]`
  - `fell_o[n] <= ~sig_i[n] & sig_q[n]`
  - `sig_q <= sig_i`
- `edge_o[n]` is registered from the same sample, selected by `mode_i[n]` in that cycle:
  - rise → rose
  - fall → fell
  - both → rose|fell
  - off → 0
- Counter n increments when `edge_o[n]` is high. It saturates at 2^CNT_W−1 and never wraps.
- `clr_i` zeroes all counters the next cycle. When `clr_i` and `edge_o[n]` occur in the same cycle, clear wins and the count is 0.
- Checker FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - On `arm_i`, latch `sel_i` and set `rem` = `window_i`, or 1 if `window_i`==0.
  - Go to WAIT.
  - An out-of-range `sel_i` (≥NCH) takes the fail path after `rem` expires.
- WAIT, evaluated each cycle on `edge_o[sel]`:
  - Edge present → DONE with pass. This holds even when `rem`==1.
  - No edge and `rem`==1 → DONE with fail.
  - Otherwise decrement `rem`.
  - A channel in mode off can only fail.
- DONE: lasts one cycle with exactly one of `pass_o`/`fail_o` high, then goes to IDLE.
- `arm_i` in WAIT or DONE is ignored and not queued.
- `rst` mid-operation returns the FSM to IDLE and clears all state. No `pass_o`/`fail_o` pulse is produced for the aborted check.

## Timing
- Reset values: all outputs 0, `sig_q` 0, counters 0, FSM IDLE, `rem` 0.
- Edge latency: a transition sampled at posedge k raises `rose_o`/`fell_o`/`edge_o` during cycle k+1, for one cycle.
- Count latency: `count_o` reflects an edge one cycle after `edge_o`, at k+2.
- Window: arm sampled at posedge a puts FSM in WAIT at a+1 with `busy_o`=1. Edges visible on `edge_o` in cycles a+1 … a+W (W = effective window) pass.
  - Result is in DONE one cycle after the deciding cycle, so `pass_o`/`fail_o` is high at a+2 … a+W+1.
  - An edge already on `edge_o` in the arm cycle does not count.
- Back-to-back checks: the earliest re-arm is accepted in the cycle after DONE.

## Structure
- Package `edge_monitor_pkg` holds:
  - `mode_e` (RISE, FALL, BOTH, OFF)
  - `chk_state_e` (IDLE, WAIT, DONE)
- Sub-module `edge_monitor_ch`: one channel. It contains `sig_q`, rose/fell/edge registers and the saturating counter, and is instantiated NCH times by generate.
- The top holds the checker FSM, `rem` counter and channel mux.

## Test plan
- Reset with `sig_i`=4'b0001 held → cycle 1 after reset `rose_o`=0001, `edge_o`=0001 (all modes RISE), `count_o`[ch0]=1 one cycle later.
- Channel 1 in BOTH, toggled 3 times → `edge_o[1]` pulses 3 times, `count_o`[ch1]=3. Channel 2 in OFF with the same toggles → count stays 0.
- CNT_W=2, 5 rises on ch0 → count reads 1, 2, 3, 3, 3. `clr_i` in the same cycle as an edge → count 0.
- Arm sel=0, window=3, rise at a+3 → `pass_o` at a+4, `busy_o` high a+1…a+3. No edge → `fail_o` at a+4.
- window=0 with no edge → `fail_o` at a+2. `arm_i` pulsed during WAIT → no second result.
- `rst` asserted while in WAIT → no `pass_o`/`fail_o`, `busy_o`=0 next cycle, counters 0.

Source files
------------

// File: rtl/edge_monitor_pkg.sv
// Shared types and helpers for the edge monitor.
package edge_monitor_pkg;

    // Per-channel edge qualification mode, 2 bits per channel on mode_i.
    typedef enum logic [1:0] {
        RISE = 2'b00,
        FALL = 2'b01,
        BOTH = 2'b10,
        OFF  = 2'b11
    } mode_e;

    // Edge-within-window checker states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } chk_state_e;

    // Width of a channel select for n channels, never below one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_monitor_ch.sv
// One monitored channel: edge detection, mode qualification, saturating count.
module edge_monitor_ch
    import edge_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             rose_o,
    output logic             fell_o,
    output logic             edge_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic  sig_q;
    logic  rise_c;
    logic  fall_c;
    logic  qual_c;
    mode_e mode;

    assign mode = mode_e'(mode_i);

    // Edge terms from the current sample against the previous one.
    always_comb begin
        rise_c = sig_i & ~sig_q;
        fall_c = ~sig_i & sig_q;
        qual_c = 1'b0;
        case (mode)
            RISE:    qual_c = rise_c;
            FALL:    qual_c = fall_c;
            BOTH:    qual_c = rise_c | fall_c;
            default: qual_c = 1'b0;
        endcase
    end

    // Previous-sample register and registered edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q  <= 1'b0;
            rose_o <= 1'b0;
            fell_o <= 1'b0;
            edge_o <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            rose_o <= rise_c;
            fell_o <= fall_c;
            edge_o <= qual_c;
        end
    end

    // Saturating edge counter fed by the registered edge; clear has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (edge_o && (count_o != CNT_MAX)) begin
            count_o <= count_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/edge_monitor.sv
// Multi-channel edge monitor with an armed edge-within-window checker.
module edge_monitor
    import edge_monitor_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NCH-1:0]                         sig_i,
    input  logic [2*NCH-1:0]                       mode_i,
    input  logic                                   clr_i,
    input  logic                                   arm_i,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel_i,
    input  logic [WIN_W-1:0]                       window_i,
    output logic [NCH-1:0]                         rose_o,
    output logic [NCH-1:0]                         fell_o,
    output logic [NCH-1:0]                         edge_o,
    output logic [NCH*CNT_W-1:0]                   count_o,
    output logic                                   busy_o,
    output logic                                   pass_o,
    output logic                                   fail_o
);

    localparam int unsigned SEL_W = sel_width(NCH);
    localparam int unsigned SEL_N = 1 << SEL_W;

    chk_state_e        state;
    logic [SEL_W-1:0]  sel_q;
    logic [WIN_W-1:0]  rem;
    logic [SEL_N-1:0]  edge_pad;
    logic              edge_sel;

    // Channel slices.
    for (genvar n = 0; n < NCH; n++) begin : g_ch
        edge_monitor_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig_i   (sig_i[n]),
            .mode_i  (mode_i[2*n +: 2]),
            .clr_i   (clr_i),
            .rose_o  (rose_o[n]),
            .fell_o  (fell_o[n]),
            .edge_o  (edge_o[n]),
            .count_o (count_o[n*CNT_W +: CNT_W])
        );
    end

    // Zero-padded edge vector so an out-of-range select reads as no edge.
    assign edge_pad = SEL_N'(edge_o);
    assign edge_sel = edge_pad[sel_q];

    // Checker FSM: arm in IDLE, count down the window in WAIT, pulse result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel_q  <= '0;
            rem    <= '0;
            busy_o <= 1'b0;
            pass_o <= 1'b0;
            fail_o <= 1'b0;
        end else begin
            pass_o <= 1'b0;
            fail_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm_i) begin
                        sel_q  <= sel_i;
                        rem    <= (window_i == '0) ? WIN_W'(1) : window_i;
                        busy_o <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (edge_sel) begin
                        pass_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else if (rem == WIN_W'(1)) begin
                        fail_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= DONE;
                    end else begin
                        rem <= rem - WIN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_monitor.sv
// Self-checking bench for edge_monitor against a history-based reference model.
module tb_edge_monitor;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned WIN_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned VW    = 3*NCH + NCH*CNT_W + 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NCH-1:0]         sig;
    logic [2*NCH-1:0]       mode;
    logic                   clr;
    logic                   arm;
    logic [SEL_W-1:0]       sel;
    logic [WIN_W-1:0]       win;
    logic [NCH-1:0]         rose_o, fell_o, edge_o;
    logic [NCH*CNT_W-1:0]   count_o;
    logic                   busy_o, pass_o, fail_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_monitor #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_i    (sig),
        .mode_i   (mode),
        .clr_i    (clr),
        .arm_i    (arm),
        .sel_i    (sel),
        .window_i (win),
        .rose_o   (rose_o),
        .fell_o   (fell_o),
        .edge_o   (edge_o),
        .count_o  (count_o),
        .busy_o   (busy_o),
        .pass_o   (pass_o),
        .fail_o   (fail_o)
    );

    // Reference model state: outputs of the current cycle plus edge history.
    logic [NCH-1:0]   m_prev, m_rose, m_fell, m_edge;
    int               m_cnt [NCH];
    logic             m_busy, m_pass, m_fail;
    logic [NCH-1:0]   hist [int];
    int               cyc = 0;
    bit               act = 0;
    int               a_cyc, w_eff, c_sel;
    int               next_ok = 0;

    function automatic logic [NCH*CNT_W-1:0] m_count_flat();
        logic [NCH*CNT_W-1:0] f;
        for (int n = 0; n < NCH; n++) f[n*CNT_W +: CNT_W] = CNT_W'(m_cnt[n]);
        return f;
    endfunction

    // Apply the rules for the inputs just sampled at this posedge.
    task automatic model_update();
        int found;
        if (rst) begin
            m_prev = '0; m_rose = '0; m_fell = '0; m_edge = '0;
            for (int n = 0; n < NCH; n++) m_cnt[n] = 0;
            m_busy = 0; m_pass = 0; m_fail = 0;
            act = 0;
            next_ok = cyc + 1;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (clr) m_cnt[n] = 0;
                else if (m_edge[n] && m_cnt[n] < (1 << CNT_W) - 1) m_cnt[n]++;
            end
            m_rose = sig & ~m_prev;
            m_fell = ~sig & m_prev;
            for (int n = 0; n < NCH; n++) begin
                case (mode[2*n +: 2])
                    2'd0:    m_edge[n] = m_rose[n];
                    2'd1:    m_edge[n] = m_fell[n];
                    2'd2:    m_edge[n] = m_rose[n] | m_fell[n];
                    default: m_edge[n] = 1'b0;
                endcase
            end
            m_prev = sig;
            hist[cyc] = m_edge;
            m_busy = 0; m_pass = 0; m_fail = 0;
            if (act) begin
                found = -1;
                for (int t = a_cyc; t <= a_cyc + w_eff - 1 && t <= cyc - 1; t++)
                    if (found < 0 && c_sel < NCH && hist[t][c_sel]) found = t;
                if (found >= 0 && cyc == found + 1) begin
                    m_pass = 1; act = 0; next_ok = cyc + 2;
                end else if (found < 0 && cyc == a_cyc + w_eff) begin
                    m_fail = 1; act = 0; next_ok = cyc + 2;
                end else begin
                    m_busy = 1;
                end
            end else if (arm && cyc >= next_ok) begin
                act = 1; a_cyc = cyc; c_sel = int'(sel);
                w_eff = (win == 0) ? 1 : int'(win);
                m_busy = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; sig = 4'b0001; mode = '0; clr = 0; arm = 0; sel = '0; win = '0;
        step();
        checks++;
        if ({rose_o, fell_o, edge_o, count_o, busy_o, pass_o, fail_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got %0h want 0",
                     {rose_o, fell_o, edge_o, count_o, busy_o, pass_o, fail_o});
        end
        rst = 0;
        step();
        checks++;
        if (rose_o !== 4'b0001 || edge_o !== 4'b0001) begin
            errors++;
            $display("FAIL first_rise got rose=%b edge=%b want 0001/0001", rose_o, edge_o);
        end
        step();
        checks++;
        if (count_o[0 +: CNT_W] !== CNT_W'(1) || rose_o !== 4'b0000) begin
            errors++;
            $display("FAIL first_count got cnt=%0d rose=%b want 1/0000", count_o[0 +: CNT_W], rose_o);
        end
    endtask

    task automatic test_both_off();
        int p1 = 0, p2 = 0;
        sig = '0; mode = 8'b00_11_10_00; clr = 1;
        step();
        clr = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            sig[1] = ~sig[1]; sig[2] = ~sig[2];
            step();
            p1 += int'(edge_o[1]); p2 += int'(edge_o[2]);
            step();
            p1 += int'(edge_o[1]); p2 += int'(edge_o[2]);
        end
        step();
        checks++;
        if (p1 != 3 || p2 != 0) begin
            errors++;
            $display("FAIL both_off_pulses got ch1=%0d ch2=%0d want 3/0", p1, p2);
        end
        checks++;
        if (count_o[1*CNT_W +: CNT_W] !== CNT_W'(3) || count_o[2*CNT_W +: CNT_W] !== '0) begin
            errors++;
            $display("FAIL both_off_count got ch1=%0d ch2=%0d want 3/0",
                     count_o[1*CNT_W +: CNT_W], count_o[2*CNT_W +: CNT_W]);
        end
    endtask

    task automatic test_saturation();
        int exp_c [5] = '{1, 2, 3, 3, 3};
        mode = '0; sig = '0; clr = 1;
        step();
        clr = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            sig[0] = 1'b1;
            step();
            sig[0] = 1'b0;
            step();
            checks++;
            if (count_o[0 +: CNT_W] !== CNT_W'(exp_c[i])) begin
                errors++;
                $display("FAIL sat_count_%0d got %0d want %0d", i, count_o[0 +: CNT_W], exp_c[i]);
            end
        end
        sig[0] = 1'b1;
        step();
        clr = 1;
        step();
        clr = 0;
        checks++;
        if (count_o[0 +: CNT_W] !== '0 || m_count_flat() !== count_o) begin
            errors++;
            $display("FAIL clr_wins got %0h want %0h", count_o, m_count_flat());
        end
    endtask

    task automatic test_checker_pass_fail();
        logic [2:0] exp_pf [5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b000};
        sig = '0; mode = '0;
        step(); step();
        arm = 1; sel = 0; win = 3;
        step();
        arm = 0;
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b100) begin
            errors++;
            $display("FAIL pass_arm got %b want 100", {busy_o, pass_o, fail_o});
        end
        step();
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b100) begin
            errors++;
            $display("FAIL pass_wait1 got %b want 100", {busy_o, pass_o, fail_o});
        end
        sig[0] = 1'b1;
        step();
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b100 || edge_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL pass_wait2 got %b edge=%b want 100 edge=1", {busy_o, pass_o, fail_o}, edge_o[0]);
        end
        step();
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b010) begin
            errors++;
            $display("FAIL pass_result got %b want 010", {busy_o, pass_o, fail_o});
        end
        step();
        arm = 1; sel = 0; win = 3;
        step();
        arm = 0;
        for (int off = 0; off < 5; off++) begin
            if (off > 0) step();
            checks++;
            if ({busy_o, pass_o, fail_o} !== exp_pf[off]) begin
                errors++;
                $display("FAIL fail_path_off%0d got %b want %b", off, {busy_o, pass_o, fail_o}, exp_pf[off]);
            end
        end
    endtask

    task automatic test_window0_and_rearm();
        logic [2:0] e;
        arm = 1; sel = 0; win = 0;
        step();
        arm = 0;
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b100) begin
            errors++;
            $display("FAIL win0_arm got %b want 100", {busy_o, pass_o, fail_o});
        end
        step();
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b001) begin
            errors++;
            $display("FAIL win0_fail got %b want 001", {busy_o, pass_o, fail_o});
        end
        step();
        arm = 1; win = 5;
        step();
        for (int off = 0; off < 9; off++) begin
            if (off > 0) step();
            arm = (off < 2);
            e = (off < 5) ? 3'b100 : (off == 5) ? 3'b001 : 3'b000;
            checks++;
            if ({busy_o, pass_o, fail_o} !== e) begin
                errors++;
                $display("FAIL arm_in_wait_off%0d got %b want %b", off, {busy_o, pass_o, fail_o}, e);
            end
        end
        arm = 0;
    endtask

    task automatic test_reset_midwait();
        int res = 0;
        arm = 1; sel = 1; win = 8;
        step();
        arm = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if ({busy_o, pass_o, fail_o} !== 3'b000 || count_o !== '0) begin
            errors++;
            $display("FAIL rst_midwait got bpf=%b cnt=%0h want 000/0", {busy_o, pass_o, fail_o}, count_o);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            res += int'(pass_o) + int'(fail_o) + int'(busy_o);
        end
        checks++;
        if (res != 0) begin
            errors++;
            $display("FAIL rst_no_result got %0d want 0", res);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] act_v, exp_v;
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 19) == 0);
            arm = ($urandom_range(0, 4) == 0);
            sel = SEL_W'($urandom_range(0, NCH - 1));
            win = WIN_W'($urandom_range(0, 7));
            sig = NCH'($urandom);
            if ($urandom_range(0, 29) == 0) mode = (2*NCH)'($urandom);
            step();
            act_v = {rose_o, fell_o, edge_o, count_o, busy_o, pass_o, fail_o};
            exp_v = {m_rose, m_fell, m_edge, m_count_flat(), m_busy, m_pass, m_fail};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d got %h want %h", cyc, act_v, exp_v);
                bad++;
            end
        end
        rst = 0; clr = 0; arm = 0;
    endtask

    initial begin
        test_reset();
        test_both_off();
        test_saturation();
        test_checker_pass_fail();
        test_window0_and_rearm();
        test_reset_midwait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
